msi_axi_responder: RTL and testbench
====================================

// Module: msi_axi_responder
// PURPOSE
// - Responder end of the MSI request/grant interface. Sits where the PCIe bridge normally does; used with PCIe cores that have no native MSI port.
// - Latches each MSI request (vector number), turns it into one AXI4-Lite write of MSI data to the MSI address, then pulses grant back to the requester.
// - One request in flight; requests arriving while busy are dropped and flagged.
// PARAMETERS
// - AddrWidth_Gen     32     AXI address width (32 or 64).
// - TimeoutCycles_Gen 1024   busy cycles before TimeoutErr sets; 0 disables the timeout.
// PORTS
// - SysClk_ClkIn          in   1   system clock.
// - SysRstN_RstIn         in   1   reset, asynchronous, active-low.
// - MsiEnable_EnIn        in   1   MSI enable from PCIe config space.
// - MsiMultiMsgEn_DatIn   in   3   Multiple Message Enable (log2 of allocated vectors).
// - MsiAddress_DatIn      in   AddrWidth_Gen   MSI message address.
// - MsiData_DatIn         in   16  MSI message data base.
// - MsiIrqEnable_EnOut    out  1   registered copy of MsiEnable_EnIn, driven to the requester.
// - MsiVectorWidth_DatOut out  3   min(MsiMultiMsgEn_DatIn,5), registered.
// - MsiReq_ValIn          in   1   single-cycle request pulse.
// - MsiVectorNum_DatIn    in   5   vector number; valid with MsiReq_ValIn.
// - MsiGrant_ValOut       out  1   single-cycle grant pulse.
// - AxiAwAddr/AwValid/AwReady, AxiWData[31:0]/WStrb[3:0]/WValid/WReady, AxiBResp[1:0]/BValid/BReady   AXI4-Lite write master.
// - OverrunErr_ValOut / RespErr_ValOut / TimeoutErr_ValOut   out 1 each   sticky error flags.
// - ErrClear_ValIn        in   1   single-cycle pulse; clears all sticky error flags.
// BEHAVIOUR
// - Reset: all outputs 0; state Idle; AXI valids low; BReady low.
// - States: Idle -> Write -> WaitResp -> Grant -> Idle.
// - Idle: MsiReq_ValIn=1 and MsiIrqEnable_EnOut=1 -> latch vector, address and composed data; AwValid=WValid=1 next cycle.
//   - Requests are ignored while MsiIrqEnable_EnOut=0.
// - Write: AW and W handshake independently; each valid drops the cycle after its own handshake.
//   - Leave Write when both handshakes are done; BReady=1 in WaitResp.
// - WaitResp: on BValid, BResp != OKAY (2'b00) sets RespErr; go to Grant.
// - Grant: MsiGrant_ValOut=1 for exactly one cycle, then Idle.
//   - Minimum req->grant latency is 4 cycles, with AwReady=WReady=BValid permanently 1.
// - Data composition: mask = (1<<VectorWidth)-1.
//   - WData = {16'h0, MsiData[15:5], (MsiData[4:0] & ~mask) | (vector & mask)}.
//   - WStrb = 4'b0011. VectorWidth 0 means the vector is fully masked.
// - AwAddr = latched MsiAddress, low 2 bits forced to 0.
// - Request while not Idle: dropped and OverrunErr set. No grant is generated for it.
// - Simultaneous ErrClear and error event: the set wins.
// - MsiEnable_EnIn falls mid-transaction: the AXI transaction completes (no abort). The Grant pulse is suppressed; return to Idle.
// - Timeout: busy-cycle counter runs from leaving Idle. Reaching TimeoutCycles_Gen sets TimeoutErr; the FSM keeps waiting (AXI is never abandoned).
// - Config values are sampled at request latch; later config changes do not affect an in-flight write.
// - Asynchronous reset mid-transaction returns everything to the reset values immediately.
// STRUCTURE
// - Shared package:
//   - state encoding (Idle/Write/WaitResp/Grant);
//   - AXI response constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR);
//   - MSI data width constant (16).
// - One sub-module: msi_vector_merge. Combinational mask/merge of MsiData and vector; reused by future MSI-X work.
// TESTING
// - MsiData=16'h4020, MMEn=3, req vector 5, AXI always ready, BResp=OKAY -> one write of WData=32'h0000_4025 to the address; grant pulse exactly 4 cycles after req.
// - MMEn=0, vector 7 -> WData low bits unchanged (16'h4020); MMEn=7 -> VectorWidth output reads 5.
// - AwReady delayed 6 cycles, WReady immediate -> WValid drops after 1 cycle, AwValid held 6 cycles; single grant after BValid.
// - Second req 1 cycle after the first -> OverrunErr=1, exactly one write and one grant; ErrClear -> OverrunErr=0.
// - BResp=2'b10 -> RespErr=1 and grant still issued.
//   - TimeoutCycles=8 with BValid held low 20 cycles -> TimeoutErr=1, grant after BValid.
// - Deassert MsiEnable during WaitResp -> write completes, no grant.
//   - Reset asserted during Write -> valids low immediately, state Idle.

Source files
------------

// File: rtl/msi_axi_responder_pkg.sv
// Shared types and constants for the MSI responder and its vector-merge helper.
// State encoding, AXI response codes and MSI field widths live here.
package msi_axi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_GRANT     = 2'd3
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int MSI_DATA_W = 16;
  localparam int MSI_VEC_W  = 5;

  // MSI allows at most 32 vectors, so Multiple Message Enable saturates at 5.
  function automatic logic [2:0] clamp_vec_width(input logic [2:0] mmen);
    return (mmen > 3'd5) ? 3'd5 : mmen;
  endfunction

endpackage

// File: rtl/msi_vector_merge.sv
// Merges an MSI vector number into the low bits of the MSI data base,
// keeping only as many vector bits as the allocated vector width allows.
module msi_vector_merge
  import msi_axi_responder_pkg::*;
(
  input  logic [MSI_DATA_W-1:0] msi_data,
  input  logic [MSI_VEC_W-1:0]  vector_num,
  input  logic [2:0]            vec_width,
  output logic [MSI_DATA_W-1:0] merged_data
);

  logic [MSI_VEC_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MSI_VEC_W; i++) mask[i] = (3'(i) < vec_width);
  end

  assign merged_data = {msi_data[MSI_DATA_W-1:MSI_VEC_W],
                        (msi_data[MSI_VEC_W-1:0] & ~mask) | (vector_num & mask)};

endmodule

// File: rtl/msi_axi_responder.sv
// MSI request/grant responder: turns each accepted MSI request into one
// AXI4-Lite write of the composed MSI data, then pulses grant.
module msi_axi_responder
  import msi_axi_responder_pkg::*;
#(
  parameter int AddrWidth_Gen     = 32,
  parameter int TimeoutCycles_Gen = 1024
) (
  input  logic                     SysClk_ClkIn,
  input  logic                     SysRstN_RstIn,
  input  logic                     MsiEnable_EnIn,
  input  logic [2:0]               MsiMultiMsgEn_DatIn,
  input  logic [AddrWidth_Gen-1:0] MsiAddress_DatIn,
  input  logic [MSI_DATA_W-1:0]    MsiData_DatIn,
  output logic                     MsiIrqEnable_EnOut,
  output logic [2:0]               MsiVectorWidth_DatOut,
  input  logic                     MsiReq_ValIn,
  input  logic [MSI_VEC_W-1:0]     MsiVectorNum_DatIn,
  output logic                     MsiGrant_ValOut,
  output logic [AddrWidth_Gen-1:0] AxiAwAddr,
  output logic                     AxiAwValid,
  input  logic                     AxiAwReady,
  output logic [31:0]              AxiWData,
  output logic [3:0]               AxiWStrb,
  output logic                     AxiWValid,
  input  logic                     AxiWReady,
  input  logic [1:0]               AxiBResp,
  input  logic                     AxiBValid,
  output logic                     AxiBReady,
  output logic                     OverrunErr_ValOut,
  output logic                     RespErr_ValOut,
  output logic                     TimeoutErr_ValOut,
  input  logic                     ErrClear_ValIn
);

  // Wide enough to hold TimeoutCycles_Gen + 1 so saturation never hides the threshold.
  localparam int CntW = $clog2(TimeoutCycles_Gen + 2);

  state_e                   state_q, state_d;
  logic                     irq_en_q, irq_en_d;
  logic [2:0]               vec_width_q, vec_width_d;
  logic [AddrWidth_Gen-1:0] awaddr_q, awaddr_d;
  logic                     awvalid_q, awvalid_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     grant_q, grant_d;
  logic                     ovr_q, ovr_d, resp_q, resp_d, tmo_q, tmo_d;
  logic [CntW-1:0]          busy_cnt_q, busy_cnt_d;

  logic [MSI_DATA_W-1:0]    merged;
  logic                     aw_hs, w_hs, b_hs, busy;
  logic                     ovr_set, resp_set, tmo_set;

  msi_vector_merge u_merge (
    .msi_data    (MsiData_DatIn),
    .vector_num  (MsiVectorNum_DatIn),
    .vec_width   (vec_width_q),
    .merged_data (merged)
  );

  assign aw_hs = awvalid_q & AxiAwReady;
  assign w_hs  = wvalid_q & AxiWReady;
  assign b_hs  = bready_q & AxiBValid;
  assign busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    irq_en_d    = MsiEnable_EnIn;
    vec_width_d = clamp_vec_width(MsiMultiMsgEn_DatIn);
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    grant_d     = 1'b0;
    resp_set    = 1'b0;
    busy_cnt_d  = busy_cnt_q;

    if (!busy)                busy_cnt_d = '0;
    else if (busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (MsiReq_ValIn && irq_en_q) begin
          awaddr_d  = {MsiAddress_DatIn[AddrWidth_Gen-1:2], 2'b00};
          wdata_d   = {16'h0, merged};
          wstrb_d   = 4'b0011;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A valid that is already low has completed its handshake earlier.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          resp_set = (AxiBResp != AXI_RESP_OKAY);
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_d = irq_en_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ovr_set = MsiReq_ValIn && busy;
    tmo_set = (TimeoutCycles_Gen != 0) && busy && (busy_cnt_q >= CntW'(TimeoutCycles_Gen));
    ovr_d   = (ovr_q  && !ErrClear_ValIn) || ovr_set;
    resp_d  = (resp_q && !ErrClear_ValIn) || resp_set;
    tmo_d   = (tmo_q  && !ErrClear_ValIn) || tmo_set;
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state_q     <= ST_IDLE;
      irq_en_q    <= 1'b0;
      vec_width_q <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      grant_q     <= 1'b0;
      ovr_q       <= 1'b0;
      resp_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      irq_en_q    <= irq_en_d;
      vec_width_q <= vec_width_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      grant_q     <= grant_d;
      ovr_q       <= ovr_d;
      resp_q      <= resp_d;
      tmo_q       <= tmo_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign MsiIrqEnable_EnOut    = irq_en_q;
  assign MsiVectorWidth_DatOut = vec_width_q;
  assign MsiGrant_ValOut       = grant_q;
  assign AxiAwAddr             = awaddr_q;
  assign AxiAwValid            = awvalid_q;
  assign AxiWData              = wdata_q;
  assign AxiWStrb              = wstrb_q;
  assign AxiWValid             = wvalid_q;
  assign AxiBReady             = bready_q;
  assign OverrunErr_ValOut     = ovr_q;
  assign RespErr_ValOut        = resp_q;
  assign TimeoutErr_ValOut     = tmo_q;

endmodule

// File: tb/tb_msi_axi_responder.sv
// Directed testbench for msi_axi_responder: one task per scenario, inline checks,
// AXI slave behaviour driven directly from the tasks.
module tb_msi_axi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mmen = 3'd0;
  logic [31:0] maddr = 32'h0;
  logic [15:0] mdata = 16'h0;
  logic        irq_en;
  logic [2:0]  vwidth;
  logic        req = 1'b0;
  logic [4:0]  vec = 5'd0;
  logic        grant;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        ovr, rerr, terr;
  logic        eclr = 1'b0;

  int errors = 0;
  int checks = 0;

  // Bus monitor: counts handshakes/grants and captures the written beat.
  int          cyc = 0, aw_n = 0, w_n = 0, b_n = 0, grant_n = 0, grant_cyc = 0;
  logic [31:0] cap_addr = '0, cap_data = '0;
  logic [3:0]  cap_strb = '0;

  msi_axi_responder #(.AddrWidth_Gen(32), .TimeoutCycles_Gen(8)) dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .MsiEnable_EnIn(en),
    .MsiMultiMsgEn_DatIn(mmen), .MsiAddress_DatIn(maddr), .MsiData_DatIn(mdata),
    .MsiIrqEnable_EnOut(irq_en), .MsiVectorWidth_DatOut(vwidth),
    .MsiReq_ValIn(req), .MsiVectorNum_DatIn(vec), .MsiGrant_ValOut(grant),
    .AxiAwAddr(awaddr), .AxiAwValid(awvalid), .AxiAwReady(awready),
    .AxiWData(wdata), .AxiWStrb(wstrb), .AxiWValid(wvalid), .AxiWReady(wready),
    .AxiBResp(bresp), .AxiBValid(bvalid), .AxiBReady(bready),
    .OverrunErr_ValOut(ovr), .RespErr_ValOut(rerr), .TimeoutErr_ValOut(terr),
    .ErrClear_ValIn(eclr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) begin aw_n <= aw_n + 1; cap_addr <= awaddr; end
    if (wvalid && wready) begin w_n <= w_n + 1; cap_data <= wdata; cap_strb <= wstrb; end
    if (bvalid && bready) b_n <= b_n + 1;
    if (grant) begin grant_n <= grant_n + 1; grant_cyc <= cyc; end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [4:0] v, output int req_c);
    @(negedge clk);
    req = 1'b1; vec = v; req_c = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_grant(input int g0, input string nm);
    int n = 0;
    while (grant_n == g0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (grant_n == g0) begin errors++; $display("FAIL %s_grant_wait: no grant after %0d cycles", nm, n); end
    wait_cycles(2);
  endtask

  task automatic clear_errs;
    @(negedge clk); eclr = 1'b1;
    @(negedge clk); eclr = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got=%b exp=0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got=%b exp=0", wvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready got=%b exp=0", bready); end
    checks++; if ({grant, ovr, rerr, terr, irq_en} !== 5'b0) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {grant, ovr, rerr, terr, irq_en}); end
    checks++; if ({awaddr, wdata, wstrb, vwidth} !== '0) begin errors++; $display("FAIL rst_buses got addr=%h data=%h strb=%h vw=%0d exp all 0", awaddr, wdata, wstrb, vwidth); end
    @(negedge clk); rst_n = 1'b1;
    en = 1'b1; mmen = 3'd3; maddr = 32'hFEE0_1003; mdata = 16'h4020;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    wait_cycles(2);
  endtask

  task automatic test_basic;
    int a0 = aw_n, w0 = w_n, g0 = grant_n, rc;
    checks++; if (irq_en !== 1'b1) begin errors++; $display("FAIL basic_irq_en got=%b exp=1", irq_en); end
    checks++; if (vwidth !== 3'd3) begin errors++; $display("FAIL basic_vwidth got=%0d exp=3", vwidth); end
    pulse_req(5'd5, rc);
    wait_grant(g0, "basic");
    checks++; if (cap_data !== 32'h0000_4025) begin errors++; $display("FAIL basic_wdata got=%h exp=00004025", cap_data); end
    checks++; if (cap_addr !== 32'hFEE0_1000) begin errors++; $display("FAIL basic_awaddr got=%h exp=fee01000", cap_addr); end
    checks++; if (cap_strb !== 4'b0011) begin errors++; $display("FAIL basic_wstrb got=%b exp=0011", cap_strb); end
    checks++; if (grant_cyc - rc != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", grant_cyc - rc); end
    checks++; if (aw_n - a0 != 1 || w_n - w0 != 1 || grant_n - g0 != 1) begin errors++; $display("FAIL basic_counts got aw=%0d w=%0d g=%0d exp 1/1/1", aw_n - a0, w_n - w0, grant_n - g0); end
    checks++; if ({ovr, rerr, terr} !== 3'b000) begin errors++; $display("FAIL basic_errs got=%b exp=000", {ovr, rerr, terr}); end
  endtask

  task automatic test_vector_width;
    int g0, rc;
    mmen = 3'd0; wait_cycles(2);
    checks++; if (vwidth !== 3'd0) begin errors++; $display("FAIL vw0_width got=%0d exp=0", vwidth); end
    g0 = grant_n; pulse_req(5'd7, rc); wait_grant(g0, "vw0");
    checks++; if (cap_data !== 32'h0000_4020) begin errors++; $display("FAIL vw0_wdata got=%h exp=00004020", cap_data); end
    mmen = 3'd7; wait_cycles(2);
    checks++; if (vwidth !== 3'd5) begin errors++; $display("FAIL vw7_width got=%0d exp=5", vwidth); end
    g0 = grant_n; pulse_req(5'h1F, rc); wait_grant(g0, "vw5");
    checks++; if (cap_data !== 32'h0000_403F) begin errors++; $display("FAIL vw5_wdata got=%h exp=0000403f", cap_data); end
    mmen = 3'd3; wait_cycles(2);
  endtask

  task automatic test_aw_delay;
    int g0 = grant_n, a0 = aw_n, w0 = w_n, aw_hi = 0, w_hi = 0;
    awready = 1'b0;
    @(negedge clk); req = 1'b1; vec = 5'd2;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (i == 5) awready = 1'b1;
      @(negedge clk);
    end
    checks++; if (aw_hi != 6 || awvalid !== 1'b0) begin errors++; $display("FAIL awdly_awvalid got hi=%0d now=%b exp 6/0", aw_hi, awvalid); end
    checks++; if (w_hi != 1) begin errors++; $display("FAIL awdly_wvalid got hi=%0d exp=1", w_hi); end
    wait_grant(g0, "awdly");
    checks++; if (grant_n - g0 != 1 || aw_n - a0 != 1 || w_n - w0 != 1) begin errors++; $display("FAIL awdly_counts got g=%0d aw=%0d w=%0d exp 1/1/1", grant_n - g0, aw_n - a0, w_n - w0); end
    checks++; if (cap_data !== 32'h0000_4022) begin errors++; $display("FAIL awdly_wdata got=%h exp=00004022", cap_data); end
    clear_errs();
  endtask

  task automatic test_overrun;
    int g0 = grant_n, a0 = aw_n;
    @(negedge clk); req = 1'b1; vec = 5'd5;
    @(negedge clk); vec = 5'd9;
    @(negedge clk); req = 1'b0;
    wait_grant(g0, "ovr");
    wait_cycles(3);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", ovr); end
    checks++; if (grant_n - g0 != 1 || aw_n - a0 != 1) begin errors++; $display("FAIL ovr_counts got g=%0d aw=%0d exp 1/1", grant_n - g0, aw_n - a0); end
    checks++; if (cap_data !== 32'h0000_4025) begin errors++; $display("FAIL ovr_wdata got=%h exp=00004025", cap_data); end
    clear_errs(); @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", ovr); end
    // Clear on the same cycle as a new overrun: the new event must stick.
    g0 = grant_n;
    @(negedge clk); req = 1'b1; vec = 5'd1;
    @(negedge clk); eclr = 1'b1;
    @(negedge clk); req = 1'b0; eclr = 1'b0;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_setwins got=%b exp=1", ovr); end
    wait_grant(g0, "setwins");
    clear_errs();
  endtask

  task automatic test_resp_err;
    int g0 = grant_n, rc;
    bresp = 2'b10;
    pulse_req(5'd4, rc); wait_grant(g0, "resp");
    checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL resp_flag got=%b exp=1", rerr); end
    checks++; if (grant_n - g0 != 1) begin errors++; $display("FAIL resp_grant got=%0d exp=1", grant_n - g0); end
    bresp = 2'b00; clear_errs(); @(negedge clk);
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL resp_clear got=%b exp=0", rerr); end
  endtask

  task automatic test_timeout;
    int g0 = grant_n, b0 = b_n, rc;
    bvalid = 1'b0;
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL tmo_pre got=%b exp=0", terr); end
    pulse_req(5'd3, rc);
    wait_cycles(20);
    checks++; if (terr !== 1'b1 || bready !== 1'b1) begin errors++; $display("FAIL tmo_flag got terr=%b bready=%b exp 1/1", terr, bready); end
    checks++; if (grant_n != g0) begin errors++; $display("FAIL tmo_early_grant got=%0d exp=0", grant_n - g0); end
    bvalid = 1'b1;
    wait_grant(g0, "tmo");
    checks++; if (b_n - b0 != 1) begin errors++; $display("FAIL tmo_bhs got=%0d exp=1", b_n - b0); end
    clear_errs();
  endtask

  task automatic test_enable_drop;
    int g0 = grant_n, a0 = aw_n, b0 = b_n, rc;
    bvalid = 1'b0;
    pulse_req(5'd6, rc);
    @(negedge clk);
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL endrop_waitresp got bready=%b exp=1", bready); end
    en = 1'b0;
    wait_cycles(2); bvalid = 1'b1; wait_cycles(6);
    checks++; if (b_n - b0 != 1 || aw_n - a0 != 1) begin errors++; $display("FAIL endrop_write got b=%0d aw=%0d exp 1/1", b_n - b0, aw_n - a0); end
    checks++; if (grant_n != g0 || irq_en !== 1'b0) begin errors++; $display("FAIL endrop_grant got g=%0d irq=%b exp 0/0", grant_n - g0, irq_en); end
    clear_errs();
    a0 = aw_n;
    pulse_req(5'd6, rc); wait_cycles(4);
    checks++; if (aw_n != a0 || ovr !== 1'b0) begin errors++; $display("FAIL disabled_req got aw=%0d ovr=%b exp 0/0", aw_n - a0, ovr); end
    en = 1'b1; wait_cycles(2);
  endtask

  task automatic test_reset_mid;
    int g0, rc;
    awready = 1'b0;
    @(negedge clk); req = 1'b1; vec = 5'd5;
    @(negedge clk); req = 1'b0;
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got awvalid=%b exp=1", awvalid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({awvalid, wvalid, bready, irq_en} !== 4'b0) begin errors++; $display("FAIL rstmid_async got=%b exp=0000", {awvalid, wvalid, bready, irq_en}); end
    @(negedge clk); rst_n = 1'b1; awready = 1'b1;
    wait_cycles(2);
    g0 = grant_n;
    pulse_req(5'd5, rc); wait_grant(g0, "rstmid");
    checks++; if (grant_cyc - rc != 4 || cap_data !== 32'h0000_4025) begin errors++; $display("FAIL rstmid_idle got lat=%0d data=%h exp 4/00004025", grant_cyc - rc, cap_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vector_width();
    test_aw_delay();
    test_overrun();
    test_resp_err();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
